// File: rtl/csrbrg_pkg.sv
// Shared definitions for the Wishbone-to-CSR bridge: FSM state encoding and
// the default CSR word-address width.
package csrbrg_pkg;

    localparam int CSR_AW_DEFAULT = 14;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_READ_WAIT  = 3'd2,
        S_READ_LATCH = 3'd3,
        S_ACK        = 3'd4
    } state_t;

endpackage

// File: rtl/csrbrg.sv
// Wishbone classic slave to synchronous CSR bus bridge, one transfer in flight.
// Define CSRBRG_RDLATCH_EN to register csr_di before wb_dat_o (read latency 4).
module csrbrg
    import csrbrg_pkg::*;
#(
    parameter int CSR_AW = CSR_AW_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    state_t state_q, state_d;
    logic   rd_phase_q;   // 0: slaves registering csr_a, 1: csr_di valid
    logic   req;
    logic   load_req;
    logic   ack_d;
    logic   rd_capture;
    logic   dat_load;

    // Byte selects and out-of-window address bits play no part in a CSR transfer.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, wb_sel_i, wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output is given a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (req) state_d = wb_we_i ? S_WRITE : S_READ_WAIT;
            S_WRITE:      state_d = S_ACK;
`ifdef CSRBRG_RDLATCH_EN
            S_READ_WAIT:  if (rd_phase_q) state_d = S_READ_LATCH;
            S_READ_LATCH: state_d = S_ACK;
`else
            S_READ_WAIT:  if (rd_phase_q) state_d = S_ACK;
`endif
            S_ACK:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        // Master gave up before the acknowledge: drop the transfer silently.
        if (state_q != S_IDLE && state_q != S_ACK && !wb_cyc_i) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        load_req   = (state_q == S_IDLE) && req;
        ack_d      = (state_d == S_ACK);
        rd_capture = (state_q == S_READ_WAIT) && rd_phase_q && (state_d != S_IDLE);
`ifdef CSRBRG_RDLATCH_EN
        dat_load   = (state_q == S_READ_LATCH) && (state_d == S_ACK);
`else
        dat_load   = rd_capture;
`endif
    end

`ifdef CSRBRG_RDLATCH_EN
    logic [31:0] rd_hold_q;

    // Cuts the csr_di OR-tree off the path into the Wishbone read mux.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_hold_q <= '0;
        end else if (rd_capture) begin
            rd_hold_q <= csr_di;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            csr_a      <= '0;
            csr_do     <= '0;
            csr_we     <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            rd_phase_q <= 1'b0;
        end else begin
            csr_we     <= load_req & wb_we_i;
            wb_ack_o   <= ack_d;
            rd_phase_q <= (state_q == S_READ_WAIT) && !rd_phase_q &&
                          (state_d == S_READ_WAIT);
            if (load_req) begin
                csr_a  <= wb_adr_i[CSR_AW+1:2];
                csr_do <= wb_dat_i;
            end
            if (dat_load) begin
`ifdef CSRBRG_RDLATCH_EN
                wb_dat_o <= rd_hold_q;
`else
                wb_dat_o <= csr_di;
`endif
            end
        end
    end

endmodule

// File: tb/tb_csrbrg.sv
// Bench for csrbrg: directed and random Wishbone traffic, scoreboarded against a
// register-map model; a CSR slave model answers reads one cycle after csr_a.
module tb_csrbrg;

`ifdef CSRBRG_RDLATCH_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 3;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic        wb_ack_o;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di = '0;

    csrbrg dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_ack_o (wb_ack_o),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .csr_di   (csr_di)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-on contents of the CSR space; word 4 is a known register value.
    function automatic logic [31:0] init_val(input int a);
        return (a == 4) ? 32'hCAFE_0001 : (32'h5A00_0000 ^ (32'(a) * 32'h0009_E377));
    endfunction

    // CSR slave: registered read of csr_a, write on csr_we.
    logic [31:0] slave_mem [0:16383];
    logic        mem_init = 1'b1;
    always @(posedge sys_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) slave_mem[i] <= init_val(i);
        end else begin
            csr_di <= slave_mem[csr_a];
            if (csr_we) slave_mem[csr_a] <= csr_do;
        end
    end

    // Reference model: the register map as seen by the Wishbone master.
    logic [31:0] shadow [int];
    function automatic logic [31:0] model_rd(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    typedef struct {
        int          a;
        logic [31:0] d;
        int          cyc;
        bit          rd;
    } exp_t;

    exp_t ackq[$];   // expected acknowledges
    exp_t wq[$];     // expected csr_we pulses
    exp_t pq[$];     // expected csr_a for reads, at a given cycle

    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst) begin
            if (wb_ack_o) begin
                if (ackq.size() == 0) begin
                    check("unexpected_ack", 32'(wb_ack_o), 32'd0);
                end else begin
                    e = ackq.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.rd) check("rd_data", wb_dat_o, e.d);
                end
            end
            if (csr_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_csr_we", 32'(csr_we), 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("we_cycle", 32'(cyc), 32'(e.cyc));
                    check("we_addr", 32'(csr_a), 32'(e.a));
                    check("we_data", csr_do, e.d);
                end
            end
            if (pq.size() != 0 && pq[0].cyc == cyc) begin
                e = pq.pop_front();
                check("rd_addr", 32'(csr_a), 32'(e.a));
            end
        end
    end

    // Starts at posedge+1 (that cycle is cycle 0), returns at posedge+1 after ack.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit keep);
        int a;
        int c0;
        bit got;
        a = int'(adr[15:2]);
        c0 = cyc;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        if (we) begin
            wq.push_back('{a: a, d: dat, cyc: c0 + 1, rd: 1'b0});
            ackq.push_back('{a: a, d: 32'd0, cyc: c0 + 2, rd: 1'b0});
            shadow[a] = dat;
        end else begin
            pq.push_back('{a: a, d: 32'd0, cyc: c0 + 1, rd: 1'b1});
            ackq.push_back('{a: a, d: model_rd(a), cyc: c0 + RD_LAT, rd: 1'b1});
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge sys_clk);
            got = wb_ack_o;
        end
        check("ack_seen", 32'(got), 32'd1);
        @(posedge sys_clk);
        #1;
        if (!keep) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(wb_ack_o), 32'd0);
        check({tag, "_dat_o"},  wb_dat_o,      32'd0);
        check({tag, "_csr_a"},  32'(csr_a),    32'd0);
        check({tag, "_csr_we"}, 32'(csr_we),   32'd0);
        check({tag, "_csr_do"}, csr_do,        32'd0);
    endtask

    initial begin
        #2 sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_all_zero("reset");
        mem_init = 1'b0;
        sys_rst  = 1'b1;
        @(posedge sys_clk);
        #1;

        // Directed: single write, single read, back-to-back, partial select.
        xfer(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 1'b0);
        xfer(1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0);
        xfer(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'hF, 1'b1);
        xfer(1'b0, 32'h0000_1234, 32'h0,         4'hF, 1'b0);
        xfer(1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0001, 1'b0);
        xfer(1'b0, 32'h0000_0044, 32'h0,         4'b0001, 1'b0);

        // Abort: cyc dropped in READ_WAIT, no ack, next read follows directly.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0000_0200;
        pq.push_back('{a: 32'h80, d: 32'd0, cyc: cyc + 1, rd: 1'b1});
        @(posedge sys_clk);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge sys_clk);
        check("abort_ack", 32'(wb_ack_o), 32'd0);
        @(posedge sys_clk);
        #1;
        xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0);

        // Reset in cycle 2 of a read: outputs clear at once, read never acked.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0000_1234;
        pq.push_back('{a: 32'h48D, d: 32'd0, cyc: cyc + 1, rd: 1'b1});
        repeat (2) begin
            @(posedge sys_clk);
            #1;
        end
        sys_rst  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            check("midrst_no_ack", 32'(wb_ack_o), 32'd0);
        end
        @(posedge sys_clk);
        #1;

        // Random traffic over a small window plus the top CSR word.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] adr;
            logic [13:0] idx;
            idx = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
            adr = $urandom;
            adr[15:2] = idx;
            xfer(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom),
                 $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge sys_clk);
                #1;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (6) @(posedge sys_clk);
        @(negedge sys_clk);
        check("ackq_drained", 32'(ackq.size()), 32'd0);
        check("wq_drained",   32'(wq.size()),   32'd0);
        check("pq_drained",   32'(pq.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
